pulse_event_arbiter: RTL and testbench

PULSE_EVENT_ARBITER -- requirements
Module: pulse_event_arbiter

---
 rtl/pulse_event_arbiter.sv | 171 +++++++++++++++++
 tb/tb_pulse_event_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_event_arbiter.sv
//-----------------------------------------------------------------------------
// pulse_event_arbiter
//
// Collects single-cycle event pulses on NUM_CH channels into per-channel
// saturating counters. A round-robin arbiter offers the pending events
// downstream one at a time through a valid/ready handshake.
//
// Parameters
//   NUM_CH    number of pulse channels (power of 2, 2..16)
//   CNT_W     width of each per-channel pending-event counter
//   ID_W      channel index width, derived from NUM_CH
//
// Ports
//   CLK        clock; all logic runs on its rising edge
//   RST        synchronous active-high reset
//   PULSE_IN   per-channel single-cycle event pulses (already in CLK domain)
//   EN         allows the arbiter to start new offers
//   EVT_VALID  an event is being offered downstream
//   EVT_ID     channel index of the offered event
//   EVT_READY  downstream accepts the current offer
//   PENDING    bit i set while channel i's counter is nonzero
//   OVF        sticky per-channel overflow flags
//   OVF_CLR    clears the matching OVF bits
//-----------------------------------------------------------------------------
module pulse_event_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 3,
    localparam int ID_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] PULSE_IN,
    input  logic              EN,
    output logic              EVT_VALID,
    output logic [ID_W-1:0]   EVT_ID,
    input  logic              EVT_READY,
    output logic [NUM_CH-1:0] PENDING,
    output logic [NUM_CH-1:0] OVF,
    input  logic [NUM_CH-1:0] OVF_CLR
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [ID_W-1:0]               r_id;
    logic [ID_W-1:0]               r_last;
    logic [NUM_CH-1:0][CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0]  w_cnt_nxt;
    logic [NUM_CH-1:0]             r_ovf;
    logic [NUM_CH-1:0]             w_ovf_set;
    logic [NUM_CH-1:0]             w_pending;
    logic [NUM_CH-1:0]             w_dec;
    logic                          w_sel_found;
    logic [ID_W-1:0]               w_sel_id;
    logic                          w_load;
    logic                          w_accept;

    //-------------------------------------------------------------------------
    // Pending vector straight from the registered counters
    //-------------------------------------------------------------------------
    always_comb begin
        w_pending = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_pending[i] = |r_cnt[i];
        end
    end

    //-------------------------------------------------------------------------
    // Round-robin pick: scan upward from r_last+1. The index wraps naturally
    // because NUM_CH is a power of two, and the final probe (k == NUM_CH)
    // lands back on r_last itself so that channel has lowest priority.
    //-------------------------------------------------------------------------
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (!w_sel_found && w_pending[ID_W'(r_last + ID_W'(k))]) begin
                w_sel_found = 1'b1;
                w_sel_id    = ID_W'(r_last + ID_W'(k));
            end
        end
    end

    //-------------------------------------------------------------------------
    // FSM next state / handshake decode
    //-------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (EN && w_sel_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                // EN is not consulted here: an offer always runs to completion
                if (EVT_READY) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_last  <= ID_W'(NUM_CH - 1);
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_id <= w_sel_id;
            end
            if (w_accept) begin
                r_last <= r_id;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Counter update. A pulse and an acceptance on the same channel cancel,
    // so the overflow flag is raised only by an uncancelled pulse at CNT_MAX.
    //-------------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_set = '0;
        w_dec     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_dec[i] = w_accept && (r_id == ID_W'(i));
            if (PULSE_IN[i] && !w_dec[i]) begin
                if (r_cnt[i] == CNT_MAX) begin
                    w_ovf_set[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else if (w_dec[i] && !PULSE_IN[i]) begin
                w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            // set has priority over a coincident clear
            r_ovf <= w_ovf_set | (r_ovf & ~OVF_CLR);
        end
    end

    assign EVT_VALID = (r_state == OFFER);
    assign EVT_ID    = r_id;
    assign PENDING   = w_pending;
    assign OVF       = r_ovf;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
//-----------------------------------------------------------------------------
// tb_pulse_event_arbiter
//
// Directed bench for pulse_event_arbiter (NUM_CH=4, CNT_W=3). Inputs change
// and outputs are sampled 1 time unit after each rising edge.
//-----------------------------------------------------------------------------
module tb_pulse_event_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] PULSE_IN;
    logic       EN;
    logic       EVT_VALID;
    logic [1:0] EVT_ID;
    logic       EVT_READY;
    logic [3:0] PENDING;
    logic [3:0] OVF;
    logic [3:0] OVF_CLR;

    int errors = 0;
    int checks = 0;

    pulse_event_arbiter #(
        .NUM_CH (4),
        .CNT_W  (3)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PULSE_IN  (PULSE_IN),
        .EN        (EN),
        .EVT_VALID (EVT_VALID),
        .EVT_ID    (EVT_ID),
        .EVT_READY (EVT_READY),
        .PENDING   (PENDING),
        .OVF       (OVF),
        .OVF_CLR   (OVF_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        PULSE_IN  = 4'b0000;
        EN        = 1'b0;
        EVT_READY = 1'b0;
        OVF_CLR   = 4'b0000;

        // ---------------- reset state
        do_reset();
        chk("rst_valid",   32'(EVT_VALID), 32'd0);
        chk("rst_id",      32'(EVT_ID),    32'd0);
        chk("rst_pending", 32'(PENDING),   32'h0);
        chk("rst_ovf",     32'(OVF),       32'h0);

        // ---------------- single pulse on channel 0, two-edge latency
        PULSE_IN = 4'b0001; EN = 1'b1; EVT_READY = 1'b1;
        step();
        PULSE_IN = 4'b0000;
        chk("p0_pend_e1",  32'(PENDING),   32'h1);
        chk("p0_valid_e1", 32'(EVT_VALID), 32'd0);
        step();
        chk("p0_valid_e2", 32'(EVT_VALID), 32'd1);
        chk("p0_id_e2",    32'(EVT_ID),    32'd0);
        step();
        chk("p0_valid_e3", 32'(EVT_VALID), 32'd0);
        chk("p0_cnt0",     32'(dut.r_cnt[0]), 32'd0);
        chk("p0_pend_e3",  32'(PENDING),   32'h0);

        // ---------------- all four channels, round robin 0,1,2,3
        do_reset();
        EN = 1'b1; EVT_READY = 1'b1;
        PULSE_IN = 4'b1111;
        step();
        PULSE_IN = 4'b0000;
        chk("rr_pend", 32'(PENDING), 32'hF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr_valid_%0d", k), 32'(EVT_VALID), 32'd1);
            chk($sformatf("rr_id_%0d", k),    32'(EVT_ID),    32'(k));
            step();
            chk($sformatf("rr_gap_%0d", k),   32'(EVT_VALID), 32'd0);
        end
        chk("rr_pend_end", 32'(PENDING), 32'h0);

        // ---------------- channel 2 held off by READY=0 for 5 cycles
        EVT_READY = 1'b0;
        PULSE_IN  = 4'b0100;
        step();
        PULSE_IN  = 4'b0000;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold_valid_%0d", k), 32'(EVT_VALID),       32'd1);
            chk($sformatf("hold_id_%0d", k),    32'(EVT_ID),          32'd2);
            chk($sformatf("hold_cnt_%0d", k),   32'(dut.r_cnt[2]),    32'd1);
            if (k < 4) step();
        end
        EVT_READY = 1'b1;
        step();
        chk("hold_valid_acc", 32'(EVT_VALID),    32'd0);
        chk("hold_cnt_acc",   32'(dut.r_cnt[2]), 32'd0);

        // ---------------- saturation and overflow on channel 1 with EN=0
        EN = 1'b0;
        PULSE_IN = 4'b0010;
        for (int k = 0; k < 7; k++) step();
        chk("sat_cnt7",  32'(dut.r_cnt[1]), 32'd7);
        chk("sat_ovf7",  32'(OVF),          32'h0);
        chk("sat_valid", 32'(EVT_VALID),    32'd0);
        step();
        chk("sat_cnt8",  32'(dut.r_cnt[1]), 32'd7);
        chk("sat_ovf8",  32'(OVF),          32'h2);
        PULSE_IN = 4'b0000;
        step();
        chk("ovf_hold",  32'(OVF),          32'h2);
        OVF_CLR = 4'b0010;
        step();
        OVF_CLR = 4'b0000;
        chk("ovf_clr",   32'(OVF),          32'h0);
        PULSE_IN = 4'b0010; OVF_CLR = 4'b0010;
        step();
        PULSE_IN = 4'b0000; OVF_CLR = 4'b0000;
        chk("ovf_set_wins", 32'(OVF),          32'h2);
        chk("ovf_cnt_sat",  32'(dut.r_cnt[1]), 32'd7);

        // ---------------- reset in the middle of an offer
        // last accepted is 2, so channel 1 (the only pending) is offered
        EN = 1'b1; EVT_READY = 1'b0;
        PULSE_IN = 4'b0001;
        step();
        chk("mid_valid", 32'(EVT_VALID), 32'd1);
        chk("mid_id",    32'(EVT_ID),    32'd1);
        RST = 1'b1; PULSE_IN = 4'b1000; OVF_CLR = 4'b0000;
        step();
        RST = 1'b0; PULSE_IN = 4'b0000;
        chk("mrst_valid", 32'(EVT_VALID), 32'd0);
        chk("mrst_pend",  32'(PENDING),   32'h0);
        chk("mrst_ovf",   32'(OVF),       32'h0);
        chk("mrst_id",    32'(EVT_ID),    32'd0);
        EVT_READY = 1'b1;
        PULSE_IN  = 4'b1001;
        step();
        PULSE_IN  = 4'b0000;
        step();
        chk("mrst_first_v",  32'(EVT_VALID), 32'd1);
        chk("mrst_first_id", 32'(EVT_ID),    32'd0);
        step();
        step();
        chk("mrst_second_id", 32'(EVT_ID),   32'd3);
        step();
        chk("mrst_pend_end", 32'(PENDING),   32'h0);

        // ---------------- pulse coinciding with acceptance on channel 3
        EVT_READY = 1'b0;
        PULSE_IN  = 4'b1000;
        step();
        PULSE_IN  = 4'b0000;
        step();
        chk("coin_id", 32'(EVT_ID), 32'd3);
        EVT_READY = 1'b1;
        PULSE_IN  = 4'b1000;
        step();
        PULSE_IN  = 4'b0000;
        chk("coin_cnt",   32'(dut.r_cnt[3]), 32'd1);
        chk("coin_valid", 32'(EVT_VALID),    32'd0);
        chk("coin_pend",  32'(PENDING),      32'h8);
        step();
        chk("coin_reoffer_v",  32'(EVT_VALID), 32'd1);
        chk("coin_reoffer_id", 32'(EVT_ID),    32'd3);
        step();
        chk("coin_pend_end", 32'(PENDING), 32'h0);

        // ---------------- EN falling mid-offer does not abort it
        EVT_READY = 1'b0;
        PULSE_IN  = 4'b0101;
        step();
        PULSE_IN  = 4'b0000;
        step();
        chk("en_offer_id", 32'(EVT_ID), 32'd0);
        EN = 1'b0;
        step();
        chk("en_keep_v",  32'(EVT_VALID), 32'd1);
        chk("en_keep_id", 32'(EVT_ID),    32'd0);
        EVT_READY = 1'b1;
        step();
        chk("en_acc_v", 32'(EVT_VALID), 32'd0);
        step();
        chk("en_idle_v",    32'(EVT_VALID), 32'd0);
        chk("en_idle_pend", 32'(PENDING),   32'h4);
        EN = 1'b1;
        step();
        chk("en_resume_v",  32'(EVT_VALID), 32'd1);
        chk("en_resume_id", 32'(EVT_ID),    32'd2);
        step();
        chk("en_pend_end", 32'(PENDING), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
